// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter with a 4-entry byte FIFO.
// TXDATA at BASE_ADDR (write pushes a byte, read returns FIFO count),
// STATUS at BASE_ADDR+4 (read {overflow, full, busy}, any write clears overflow).
//
// state | meaning
// ------+---------------------------------------------------
// IDLE  | line high, waiting for a byte in the FIFO
// START | start bit (tx=0) held CLKS_PER_BIT cycles
// DATA  | eight data bits, LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bit (tx=1) held CLKS_PER_BIT cycles
module uart_tx_periph #(
  parameter int LENGTH = 32,
  parameter int CLKS_PER_BIT = 434,
  parameter logic [LENGTH-1:0] BASE_ADDR = 32'h1001_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              MemWrite,
  input  logic [LENGTH-1:0] HADDR,
  input  logic [LENGTH-1:0] HWDATA,
  output logic [LENGTH-1:0] HRDATA_Uart,
  output logic              tx,
  output logic              busy
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [LENGTH-1:0] STATUS_ADDR = BASE_ADDR + LENGTH'(4);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} stateT;

  stateT             state, stateNext;
  logic [BAUD_W-1:0] baudCnt, baudNext;
  logic [2:0]        bitIdx, bitNext;
  logic [7:0]        shiftReg, shiftNext;
  logic              txNext;

  logic [7:0] fifoMem [4];
  logic [1:0] wrPtr, rdPtr;
  logic [2:0] count;
  logic       overflow;

  logic writeData, writeStatus, full, push, pop;
  logic unusedHighBits;

  assign unusedHighBits = ^HWDATA[LENGTH-1:8];

  assign writeData   = MemWrite && (HADDR == BASE_ADDR);
  assign writeStatus = MemWrite && (HADDR == STATUS_ADDR);
  assign full        = (count == 3'd4);
  // Full is judged on the pre-edge count, so a push at count=4 is lost even if the FSM pops.
  assign push        = writeData && !full;
  assign busy        = (state != IDLE) || (count != 3'd0);

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (push) fifoMem[wrPtr] <= HWDATA[7:0];
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr    <= 2'd0;
      rdPtr    <= 2'd0;
      count    <= 3'd0;
      overflow <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + 2'd1;
      if (pop)  rdPtr <= rdPtr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (writeStatus)
        overflow <= 1'b0;
      else if (writeData && full)
        overflow <= 1'b1;
    end
  end

  // Transmit FSM state, baud/bit counters, shift register and registered tx.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baudCnt  <= '0;
      bitIdx   <= 3'd0;
      shiftReg <= 8'd0;
      tx       <= 1'b1;
    end else begin
      state    <= stateNext;
      baudCnt  <= baudNext;
      bitIdx   <= bitNext;
      shiftReg <= shiftNext;
      tx       <= txNext;
    end
  end

  // Next-state and next-output decode for the transmit FSM.
  always_comb begin
    stateNext = state;
    baudNext  = baudCnt;
    bitNext   = bitIdx;
    shiftNext = shiftReg;
    txNext    = tx;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        txNext = 1'b1;
        if (count != 3'd0) begin
          pop       = 1'b1;
          shiftNext = fifoMem[rdPtr];
          baudNext  = '0;
          txNext    = 1'b0;
          stateNext = START;
        end
      end
      START: begin
        if (baudCnt == BAUD_LAST) begin
          baudNext  = '0;
          bitNext   = 3'd0;
          txNext    = shiftReg[0];
          stateNext = DATA;
        end else begin
          baudNext = baudCnt + 1'b1;
        end
      end
      DATA: begin
        if (baudCnt == BAUD_LAST) begin
          baudNext = '0;
          if (bitIdx == 3'd7) begin
            txNext    = 1'b1;
            stateNext = STOP;
          end else begin
            bitNext = bitIdx + 3'd1;
            txNext  = shiftReg[bitIdx + 3'd1];
          end
        end else begin
          baudNext = baudCnt + 1'b1;
        end
      end
      STOP: begin
        // Returning to IDLE here guarantees one idle cycle before the next start bit.
        if (baudCnt == BAUD_LAST) begin
          baudNext  = '0;
          stateNext = IDLE;
        end else begin
          baudNext = baudCnt + 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Combinational read mux for the core load path.
  always_comb begin
    HRDATA_Uart = '0;
    if (HADDR == STATUS_ADDR)
      HRDATA_Uart = {{(LENGTH-3){1'b0}}, overflow, full, busy};
    else if (HADDR == BASE_ADDR)
      HRDATA_Uart = {{(LENGTH-3){1'b0}}, count};
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph with CLKS_PER_BIT=4.
module tb_uart_tx_periph;

  localparam int LEN = 32;
  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam logic [31:0] STAT = BASE + 32'd4;

  logic            clock = 1'b0;
  logic            reset;
  logic            MemWrite;
  logic [LEN-1:0]  HADDR;
  logic [LEN-1:0]  HWDATA;
  logic [LEN-1:0]  HRDATA_Uart;
  logic            tx;
  logic            busy;

  int checks = 0;
  int failures = 0;
  logic [31:0] rd;

  uart_tx_periph #(.LENGTH(LEN), .CLKS_PER_BIT(4), .BASE_ADDR(BASE)) dut (
    .clock(clock), .reset(reset), .MemWrite(MemWrite), .HADDR(HADDR),
    .HWDATA(HWDATA), .HRDATA_Uart(HRDATA_Uart), .tx(tx), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic doWrite(input logic [31:0] addr, input logic [31:0] data);
    MemWrite = 1'b1;
    HADDR = addr;
    HWDATA = data;
    tick();
    MemWrite = 1'b0;
  endtask

  task automatic readReg(input logic [31:0] addr, output logic [31:0] val);
    HADDR = addr;
    #1;
    val = HRDATA_Uart;
  endtask

  // Expected tx level i cycles after the start bit first appears (i=40 is the idle gap).
  function automatic logic frameBit(input logic [7:0] b, input int i);
    if (i < 4) return 1'b0;
    if (i < 36) return b[(i - 4) / 4];
    return 1'b1;
  endfunction

  task automatic checkFrame(input string tag, input logic [7:0] b, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      tick();
      check($sformatf("%s_bit%0d", tag, i), {31'd0, tx}, {31'd0, frameBit(b, i)});
    end
  endtask

  initial begin
    reset = 1'b1;
    MemWrite = 1'b0;
    HADDR = STAT;
    HWDATA = '0;
    #2;
    check("rst_status", HRDATA_Uart, 32'd0);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    readReg(STAT, rd); check("post_rst_status", rd, 32'd0);
    readReg(BASE, rd); check("post_rst_count", rd, 32'd0);

    // Single frame 0xA5
    doWrite(BASE, 32'h0000_00A5);
    check("a5_tx_k", {31'd0, tx}, 32'd1);
    check("a5_busy_k", {31'd0, busy}, 32'd1);
    checkFrame("a5", 8'hA5, 0, 39);
    check("a5_busy_stop", {31'd0, busy}, 32'd1);
    checkFrame("a5", 8'hA5, 40, 40);
    check("a5_busy_idle", {31'd0, busy}, 32'd0);

    // Six back-to-back writes; the sixth overflows
    for (int j = 0; j < 6; j++) begin
      doWrite(BASE, 32'hFFFF_FF00 | (j + 1));
      check($sformatf("ovf_tx_w%0d", j), {31'd0, tx},
            {31'd0, (j == 0) ? 1'b1 : frameBit(8'h01, j - 1)});
    end
    readReg(STAT, rd); check("ovf_status_full", rd, 32'd7);
    readReg(BASE, rd); check("ovf_count_full", rd, 32'd4);
    checkFrame("ovf_b1", 8'h01, 5, 40);
    checkFrame("ovf_b2", 8'h02, 0, 40);
    checkFrame("ovf_b3", 8'h03, 0, 40);
    checkFrame("ovf_b4", 8'h04, 0, 40);
    checkFrame("ovf_b5", 8'h05, 0, 40);
    check("ovf_tx_idle_after", {31'd0, tx}, 32'd1);
    readReg(STAT, rd); check("ovf_status_done", rd, 32'd4);

    // Clear overflow mid-transmission
    doWrite(BASE, 32'h3C);
    check("clr_tx_k", {31'd0, tx}, 32'd1);
    doWrite(BASE, 32'hC3);
    check("clr_tx_o0", {31'd0, tx}, {31'd0, frameBit(8'h3C, 0)});
    readReg(STAT, rd); check("clr_status_before", rd, 32'd5);
    doWrite(STAT, 32'hFFFF_FFFF);
    check("clr_tx_o1", {31'd0, tx}, {31'd0, frameBit(8'h3C, 1)});
    readReg(STAT, rd); check("clr_status_after", rd, 32'd1);
    readReg(BASE, rd); check("clr_count", rd, 32'd1);
    checkFrame("clr_3c", 8'h3C, 2, 40);
    checkFrame("clr_c3", 8'hC3, 0, 40);
    readReg(STAT, rd); check("clr_status_idle", rd, 32'd0);

    // Reset during DATA bit 3
    doWrite(BASE, 32'h00);
    doWrite(BASE, 32'h55);
    checkFrame("rmid", 8'h00, 1, 17);
    readReg(BASE, rd); check("rmid_count_before", rd, 32'd1);
    reset = 1'b1;
    #1;
    check("rmid_tx_now", {31'd0, tx}, 32'd1);
    check("rmid_busy_now", {31'd0, busy}, 32'd0);
    readReg(STAT, rd); check("rmid_status_in_rst", rd, 32'd0);
    readReg(BASE, rd); check("rmid_count_in_rst", rd, 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 45; i++) begin
      tick();
      check($sformatf("rmid_quiet%0d", i), {31'd0, tx}, 32'd1);
    end
    readReg(STAT, rd); check("rmid_status_after", rd, 32'd0);
    readReg(BASE, rd); check("rmid_count_after", rd, 32'd0);

    // Decode: wrong address and MemWrite=0 do not push
    doWrite(BASE + 32'd8, 32'h77);
    readReg(BASE + 32'd8, rd); check("dec_rd_plus8", rd, 32'd0);
    HADDR = BASE;
    HWDATA = 32'h88;
    tick();
    readReg(BASE, rd); check("dec_count", rd, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("dec_tx%0d", i), {31'd0, tx}, 32'd1);
    end
    check("dec_busy", {31'd0, busy}, 32'd0);

    // Simultaneous push and pop at count=2
    doWrite(BASE, 32'h11);
    check("pp_tx_k", {31'd0, tx}, 32'd1);
    doWrite(BASE, 32'h22);
    check("pp_tx_o0", {31'd0, tx}, {31'd0, frameBit(8'h11, 0)});
    doWrite(BASE, 32'h33);
    check("pp_tx_o1", {31'd0, tx}, {31'd0, frameBit(8'h11, 1)});
    readReg(BASE, rd); check("pp_count_2", rd, 32'd2);
    checkFrame("pp_11", 8'h11, 2, 40);
    readReg(BASE, rd); check("pp_count_pre", rd, 32'd2);
    doWrite(BASE, 32'h44);
    check("pp_tx_b0", {31'd0, tx}, {31'd0, frameBit(8'h22, 0)});
    readReg(BASE, rd); check("pp_count_same", rd, 32'd2);
    checkFrame("pp_22", 8'h22, 1, 40);
    checkFrame("pp_33", 8'h33, 0, 40);
    checkFrame("pp_44", 8'h44, 0, 40);
    readReg(BASE, rd); check("pp_count_end", rd, 32'd0);
    check("pp_busy_end", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_periph.md
UART_TX_PERIPH -- requirements
Module: uart_tx_periph

Interface
REQ-001 The block SHALL have parameter LENGTH, default 32: bus data/address width.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 434: clock cycles per UART bit (50 MHz / 115200).
REQ-003 The block SHALL have parameter BASE_ADDR, default 32'h1001_0000: TXDATA register address; STATUS is at BASE_ADDR+4.
REQ-004 The block SHALL have port clock, input, 1: single rising-edge clock.
REQ-005 The block SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 The block SHALL have port MemWrite, input, 1: core store strobe.
REQ-007 The block SHALL have port HADDR, input, LENGTH: core data address.
REQ-008 The block SHALL have port HWDATA, input, LENGTH: store data (core RegisterFile_RD2_w).
REQ-009 The block SHALL have port HRDATA_Uart, output, LENGTH: combinational read data for the core load mux.
REQ-010 The block SHALL have port tx, output, 1: registered serial line, idle high.
REQ-011 The block SHALL have port busy, output, 1: FSM not IDLE or FIFO non-empty.

Function
REQ-012 Address decode SHALL compare all LENGTH bits of HADDR; any other address is ignored on write and reads 0.
REQ-013 On a clock edge with MemWrite=1, HADDR=BASE_ADDR and FIFO not full, HWDATA[7:0] SHALL be pushed; HWDATA[LENGTH-1:8] is ignored.
REQ-014 The FIFO SHALL be 4 entries, 8 bits wide, with 2-bit read/write pointers that wrap 3->0 and a 3-bit count (0..4).
REQ-015 Full SHALL be evaluated before the edge: a push while count=4 is dropped even if a pop occurs on the same edge, and the overflow flag is set.
REQ-016 A push and a pop on the same edge with 0<count<4 SHALL leave count unchanged and store/deliver the correct bytes.
REQ-017 Overflow SHALL be a sticky flag cleared only by reset or by a write (any data) to BASE_ADDR+4.
REQ-018 HRDATA_Uart SHALL be {(LENGTH-3) zeros, overflow, full, busy} when HADDR=BASE_ADDR+4; {(LENGTH-3) zeros, count} when HADDR=BASE_ADDR; 0 otherwise.
REQ-019 The FSM SHALL have states IDLE, START, DATA, STOP, with baud counter 0..CLKS_PER_BIT-1 and 3-bit bit index.
REQ-020 IDLE with count>0 at an edge: pop the head into the shift register, clear the baud counter, set tx<=0, and go to START.
REQ-021 START: after CLKS_PER_BIT cycles, tx<=shift[0], set bit index to 0, go to DATA.
REQ-022 DATA: every CLKS_PER_BIT cycles, advance one bit, LSB first; after bit 7 has been held its full period, tx<=1 and go to STOP.
REQ-023 STOP: hold tx=1 for CLKS_PER_BIT cycles, then go to IDLE; IDLE SHALL last at least one cycle before the next START.
REQ-024 Frame timing SHALL be 8N1; each bit is exactly CLKS_PER_BIT cycles; start-to-start for back-to-back bytes is 10*CLKS_PER_BIT+1 cycles.
REQ-025 tx SHALL fall on the edge after the push when the FIFO was empty and the FSM was IDLE (1-cycle latency).
REQ-026 A write during transmission SHALL not disturb the byte being shifted.

Reset
REQ-027 Asserting reset SHALL immediately force tx=1, busy=0, state=IDLE, FIFO pointers and count=0, overflow=0, and counters=0, including mid-frame.
REQ-028 The FIFO data array SHALL not require reset; HRDATA_Uart SHALL read 0 at BASE_ADDR+4 during and after reset.

Verification (CLKS_PER_BIT=4)
REQ-029 Write 0x000000A5 to BASE_ADDR at edge k -> tx low from edge k+1 for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), then stop 1 for 4 cycles; busy=1 from edge k until IDLE.
REQ-030 Six consecutive-cycle writes 0x01..0x06 -> 0x01..0x05 transmitted in order and 0x06 dropped; STATUS reads 0x7 after the sixth write; STATUS reads 0x4 after all frames complete.
REQ-031 Write to BASE_ADDR+4 while overflow=1 -> STATUS bit2 clears on the next edge; tx and FIFO are unaffected.
REQ-032 Assert reset during DATA bit 3 -> tx=1 in the same cycle; after release STATUS reads 0, count reads 0, and no further bits are emitted.
REQ-033 MemWrite=1 with HADDR=BASE_ADDR+8 and with MemWrite=0 at HADDR=BASE_ADDR -> no push, tx stays 1, and HRDATA_Uart at BASE_ADDR+8 reads 0.
REQ-034 Push and pop on the same edge at count=2 -> count remains 2 and the output byte order is preserved.
